// File: rtl/axi4_refill_resp_deserializer_gen.sv
// AXI4 R-channel refill deserializer: packs a burst of AXI_DATA-wide beats
// into one cache line, merges responses, flags short/long bursts and ID
// mismatches, passes single bypass beats through, and buffers finished lines.
module axi4_refill_resp_deserializer_gen #(
    parameter int LINE_WORDS = 4,
    parameter int WORD_WIDTH = 32,
    parameter int AXI_DATA   = 64,
    parameter int AXI_ID     = 6,
    parameter int AXI_USER   = 8,
    parameter int OUT_DEPTH  = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             bypass_i,
    input  logic [AXI_ID-1:0]                rid_i,
    input  logic [AXI_DATA-1:0]              rdata_i,
    input  logic [1:0]                       rresp_i,
    input  logic                             rlast_i,
    input  logic [AXI_USER-1:0]              ruser_i,
    input  logic                             rvalid_i,
    output logic                             rready_o,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] line_o,
    output logic [AXI_ID-1:0]                rid_o,
    output logic [1:0]                       rresp_o,
    output logic [AXI_USER-1:0]              ruser_o,
    output logic                             err_o,
    output logic                             bypass_o,
    output logic                             valid_o,
    input  logic                             ready_i
);

    localparam int LINE_W  = LINE_WORDS * WORD_WIDTH;
    localparam int BEATS   = LINE_W / AXI_DATA;
    localparam int CW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW      = $clog2(OUT_DEPTH);
    localparam int ENTRY_W = LINE_W + AXI_ID + 2 + AXI_USER + 2;

    localparam logic [CW-1:0] LAST_CNT    = CW'(BEATS - 1);
    localparam logic [PW:0]   DEPTH_CNT   = (PW + 1)'(OUT_DEPTH);
    localparam logic [1:0]    RESP_OKAY   = 2'd0;
    localparam logic [1:0]    RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    // Sticky merge: the numerically larger response wins (DECERR > SLVERR > EXOKAY > OKAY).
    function automatic logic [1:0] resp_merge(input logic [1:0] prev, input logic [1:0] beat);
        if (beat > prev) begin
            return beat;
        end else begin
            return prev;
        end
    endfunction

    // An errored line reports at least SLVERR.
    function automatic logic [1:0] resp_raise(input logic [1:0] resp, input logic err);
        if (err && (resp < RESP_SLVERR)) begin
            return RESP_SLVERR;
        end else begin
            return resp;
        end
    endfunction

    // Assembly state
    state_t                state_r;
    logic [CW-1:0]         cnt_r;
    logic [LINE_W-1:0]     asm_r;
    logic [AXI_ID-1:0]     rid_r;
    logic [AXI_USER-1:0]   ruser_r;
    logic [1:0]            resp_r;
    logic                  err_r;

    // Next-state and push controls
    state_t                state_n_s;
    logic [CW-1:0]         cnt_n_s;
    logic [LINE_W-1:0]     asm_n_s;
    logic [AXI_ID-1:0]     rid_n_s;
    logic [AXI_USER-1:0]   ruser_n_s;
    logic [1:0]            resp_n_s;
    logic                  err_n_s;
    logic                  push_s;
    logic [ENTRY_W-1:0]    push_entry_s;
    logic [LINE_W-1:0]     first_line_s;
    logic [LINE_W-1:0]     slot_line_s;
    logic [1:0]            merged_s;
    logic                  id_err_s;
    logic                  accept_s;

    // Output buffer
    logic [ENTRY_W-1:0]    mem_r [OUT_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [PW:0]           count_r;
    logic                  out_full_s;
    logic                  pop_s;
    logic [ENTRY_W-1:0]    head_s;

    assign out_full_s = (count_r == DEPTH_CNT);
    assign rready_o   = (state_r == ST_DRAIN) ? 1'b1 : !out_full_s;
    assign accept_s   = rvalid_i & rready_o;
    assign valid_o    = (count_r != {(PW + 1){1'b0}});
    assign pop_s      = valid_o & ready_i;

    // Candidate lines: a fresh line holding only slot 0, and the current line with slot cnt filled.
    always_comb begin
        first_line_s                      = {LINE_W{1'b0}};
        first_line_s[AXI_DATA-1:0]        = rdata_i;
        slot_line_s                       = asm_r;
        slot_line_s[cnt_r*AXI_DATA +: AXI_DATA] = rdata_i;
        merged_s                          = resp_merge(resp_r, rresp_i);
        id_err_s                          = err_r | (rid_i != rid_r);
    end

    // Burst sequencing: decides the next assembly state and whether a line is pushed this beat.
    always_comb begin
        state_n_s    = state_r;
        cnt_n_s      = cnt_r;
        asm_n_s      = asm_r;
        rid_n_s      = rid_r;
        ruser_n_s    = ruser_r;
        resp_n_s     = resp_r;
        err_n_s      = err_r;
        push_s       = 1'b0;
        push_entry_s = {ENTRY_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    asm_n_s   = first_line_s;
                    rid_n_s   = rid_i;
                    ruser_n_s = ruser_i;
                    resp_n_s  = rresp_i;
                    err_n_s   = 1'b0;
                    if (bypass_i) begin
                        push_s       = 1'b1;
                        push_entry_s = {1'b1, 1'b0, ruser_i, rresp_i, rid_i, first_line_s};
                    end else if (rlast_i) begin
                        // rlast on the first beat is short unless a line is one beat wide
                        push_s       = 1'b1;
                        push_entry_s = {1'b0, (BEATS > 1), ruser_i,
                                        resp_raise(rresp_i, (BEATS > 1)), rid_i, first_line_s};
                    end else if (BEATS == 1) begin
                        // one-beat lines without rlast: line is complete, rest of burst is surplus
                        push_s       = 1'b1;
                        push_entry_s = {1'b0, 1'b1, ruser_i, resp_raise(rresp_i, 1'b1),
                                        rid_i, first_line_s};
                        state_n_s    = ST_DRAIN;
                    end else begin
                        cnt_n_s   = CW'(1);
                        state_n_s = ST_COLLECT;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (accept_s) begin
                    asm_n_s  = slot_line_s;
                    resp_n_s = merged_s;
                    err_n_s  = id_err_s;
                    if (rlast_i) begin
                        push_s       = 1'b1;
                        push_entry_s = {1'b0, id_err_s | (cnt_r != LAST_CNT), ruser_r,
                                        resp_raise(merged_s, id_err_s | (cnt_r != LAST_CNT)),
                                        rid_r, slot_line_s};
                        cnt_n_s      = {CW{1'b0}};
                        state_n_s    = ST_IDLE;
                    end else if (cnt_r == LAST_CNT) begin
                        push_s       = 1'b1;
                        push_entry_s = {1'b0, 1'b1, ruser_r, resp_raise(merged_s, 1'b1),
                                        rid_r, slot_line_s};
                        cnt_n_s      = {CW{1'b0}};
                        state_n_s    = ST_DRAIN;
                    end else begin
                        cnt_n_s = cnt_r + CW'(1);
                    end
                end else begin
                    state_n_s = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                if (accept_s && rlast_i) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_DRAIN;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                cnt_n_s   = {CW{1'b0}};
            end
        endcase
    end

    // Assembly registers; reset discards any partial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            asm_r   <= {LINE_W{1'b0}};
            rid_r   <= {AXI_ID{1'b0}};
            ruser_r <= {AXI_USER{1'b0}};
            resp_r  <= RESP_OKAY;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            asm_r   <= asm_n_s;
            rid_r   <= rid_n_s;
            ruser_r <= ruser_n_s;
            resp_r  <= resp_n_s;
            err_r   <= err_n_s;
        end
    end

    // Output line FIFO with wrap-around pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW + 1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW + 1)'(1);
                2'b01:   count_r <= count_r - (PW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_s   = mem_r[rd_ptr_r];
    assign line_o   = head_s[LINE_W-1:0];
    assign rid_o    = head_s[LINE_W +: AXI_ID];
    assign rresp_o  = head_s[LINE_W + AXI_ID +: 2];
    assign ruser_o  = head_s[LINE_W + AXI_ID + 2 +: AXI_USER];
    assign err_o    = head_s[ENTRY_W-2];
    assign bypass_o = head_s[ENTRY_W-1];

endmodule

// File: tb/tb_axi4_refill_resp_deserializer_gen.sv
// Bench for axi4_refill_resp_deserializer_gen: a burst-level model predicts each
// output line; one compare process checks every consumed entry against it.
module tb_axi4_refill_resp_deserializer_gen;

    localparam int LW    = 128;
    localparam int BEATS = 2;

    typedef struct packed {
        logic [LW-1:0] line;
        logic [5:0]    rid;
        logic [1:0]    resp;
        logic [7:0]    user;
        logic          err;
        logic          byp;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          bypass_i;
    logic [5:0]    rid_i;
    logic [63:0]   rdata_i;
    logic [1:0]    rresp_i;
    logic          rlast_i;
    logic [7:0]    ruser_i;
    logic          rvalid_i;
    logic          rready_o;
    logic [LW-1:0] line_o;
    logic [5:0]    rid_o;
    logic [1:0]    rresp_o;
    logic [7:0]    ruser_o;
    logic          err_o;
    logic          bypass_o;
    logic          valid_o;
    logic          ready_i;

    // One-beat-per-line instance (AXI_DATA = 128)
    logic          b1_bypass;
    logic [5:0]    b1_rid;
    logic [127:0]  b1_rdata;
    logic [1:0]    b1_rresp;
    logic          b1_rlast;
    logic [7:0]    b1_ruser;
    logic          b1_rvalid;
    logic          b1_rready;
    logic [127:0]  b1_line;
    logic [5:0]    b1_rid_o;
    logic [1:0]    b1_resp_o;
    logic [7:0]    b1_user_o;
    logic          b1_err;
    logic          b1_byp_o;
    logic          b1_valid;
    logic          b1_ready;

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   n_exp  = 0;
    int   cyc    = 0;
    exp_t exp_q[$];

    logic [63:0] b_data [8];
    logic [5:0]  b_id   [8];
    logic [1:0]  b_resp [8];
    logic [7:0]  b_user [8];

    axi4_refill_resp_deserializer_gen u_dut (
        .clk(clk), .rst_n(rst_n), .bypass_i(bypass_i), .rid_i(rid_i), .rdata_i(rdata_i),
        .rresp_i(rresp_i), .rlast_i(rlast_i), .ruser_i(ruser_i), .rvalid_i(rvalid_i),
        .rready_o(rready_o), .line_o(line_o), .rid_o(rid_o), .rresp_o(rresp_o),
        .ruser_o(ruser_o), .err_o(err_o), .bypass_o(bypass_o), .valid_o(valid_o),
        .ready_i(ready_i)
    );

    axi4_refill_resp_deserializer_gen #(.AXI_DATA(128)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bypass_i(b1_bypass), .rid_i(b1_rid), .rdata_i(b1_rdata),
        .rresp_i(b1_rresp), .rlast_i(b1_rlast), .ruser_i(b1_ruser), .rvalid_i(b1_rvalid),
        .rready_o(b1_rready), .line_o(b1_line), .rid_o(b1_rid_o), .rresp_o(b1_resp_o),
        .ruser_o(b1_user_o), .err_o(b1_err), .bypass_o(b1_byp_o), .valid_o(b1_valid),
        .ready_i(b1_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count for throughput measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_beat(input int k, input logic [63:0] d, input logic [5:0] id,
                            input logic [1:0] resp, input logic [7:0] user);
        b_data[k] = d;
        b_id[k]   = id;
        b_resp[k] = resp;
        b_user[k] = user;
    endtask

    // Burst-level model: what one burst of n beats must turn into.
    function automatic exp_t model_burst(input int n, input bit byp);
        exp_t e;
        int   filled;
        e      = '0;
        e.rid  = b_id[0];
        e.user = b_user[0];
        e.resp = b_resp[0];
        e.byp  = byp;
        if (byp) begin
            e.line[63:0] = b_data[0];
            return e;
        end
        filled = (n < BEATS) ? n : BEATS;
        for (int k = 0; k < filled; k++) begin
            e.line[k*64 +: 64] = b_data[k];
            if (b_resp[k] > e.resp) e.resp = b_resp[k];
            if (b_id[k] != b_id[0]) e.err = 1'b1;
        end
        if (n != BEATS) e.err = 1'b1;
        if (e.err && (e.resp < 2'd2)) e.resp = 2'd2;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat was taken.
    task automatic wait_accept();
        int w   = 0;
        bit got = 1'b0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            got = rready_o;
            @(posedge clk);
            #1;
            if (got) begin
                done = 1'b1;
            end else begin
                w++;
                if (w > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout actual=stalled required=accepted");
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic send_burst(input int n, input bit byp, input bit add_model);
        if (add_model) begin
            exp_q.push_back(model_burst(n, byp));
            n_exp++;
        end
        for (int k = 0; k < n; k++) begin
            rvalid_i = 1'b1;
            rdata_i  = b_data[k];
            rid_i    = b_id[k];
            rresp_i  = b_resp[k];
            ruser_i  = b_user[k];
            rlast_i  = (k == n - 1);
            bypass_i = (k == 0) ? byp : 1'b0;
            wait_accept();
        end
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        bypass_i = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (((exp_q.size() != 0) || valid_o) && (w < 100)) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [127:0] d, input logic [1:0] resp, input logic last);
        b1_rvalid = 1'b1;
        b1_rdata  = d;
        b1_rresp  = resp;
        b1_rlast  = last;
        b1_rid    = 6'h2A;
        b1_ruser  = 8'hC3;
        @(negedge clk);
        chk("b1_rready", b1_rready, 1);
        @(posedge clk);
        #1;
        b1_rvalid = 1'b0;
        b1_rlast  = 1'b0;
    endtask

    // Compare every consumed output entry against the model queue.
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=line %h required=none", line_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_line", line_o, e.line);
                chk("out_rid", rid_o, e.rid);
                chk("out_rresp", rresp_o, e.resp);
                chk("out_ruser", ruser_o, e.user);
                chk("out_err", err_o, e.err);
                chk("out_bypass", bypass_o, e.byp);
                n_out++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n = 1'b0; ready_i = 1'b1; bypass_i = 1'b0; rid_i = '0; rdata_i = '0;
        rresp_i = '0; rlast_i = 1'b0; ruser_i = '0; rvalid_i = 1'b0;
        b1_bypass = 1'b0; b1_rid = '0; b1_rdata = '0; b1_rresp = '0; b1_rlast = 1'b0;
        b1_ruser = '0; b1_rvalid = 1'b0; b1_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", valid_o, 0);
        chk("rst_line", line_o, 0);
        chk("rst_rid", rid_o, 0);
        chk("rst_rresp", rresp_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_bypass", bypass_o, 0);
        chk("rst_rready", rready_o, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic 2-beat burst with literal expectations
        set_beat(0, 64'h1111_2222_3333_4444, 6'h05, 2'd0, 8'h11);
        set_beat(1, 64'h5555_6666_7777_8888, 6'h05, 2'd0, 8'h22);
        send_burst(2, 1'b0, 1'b1);
        @(negedge clk);
        chk("lit_basic_valid", valid_o, 1);
        chk("lit_basic_line", line_o, 128'h5555_6666_7777_8888_1111_2222_3333_4444);
        chk("lit_basic_resp", rresp_o, 2'd0);
        chk("lit_basic_err", err_o, 0);
        @(posedge clk);
        #1;

        // Back-to-back bursts: 4 beats in 4 cycles
        c0 = cyc;
        set_beat(0, 64'hA0A0_0000_0000_0001, 6'h07, 2'd0, 8'h31);
        set_beat(1, 64'hA0A0_0000_0000_0002, 6'h07, 2'd0, 8'h32);
        send_burst(2, 1'b0, 1'b1);
        set_beat(0, 64'hB0B0_0000_0000_0001, 6'h08, 2'd0, 8'h41);
        set_beat(1, 64'hB0B0_0000_0000_0002, 6'h08, 2'd0, 8'h42);
        send_burst(2, 1'b0, 1'b1);
        chk("throughput_cycles", cyc - c0, 4);

        // Response merging
        set_beat(0, 64'hC000_0000_0000_0001, 6'h01, 2'd1, 8'h51);
        set_beat(1, 64'hC000_0000_0000_0002, 6'h01, 2'd2, 8'h52);
        send_burst(2, 1'b0, 1'b1);
        set_beat(0, 64'hD000_0000_0000_0001, 6'h02, 2'd3, 8'h61);
        set_beat(1, 64'hD000_0000_0000_0002, 6'h02, 2'd0, 8'h62);
        send_burst(2, 1'b0, 1'b1);
        @(negedge clk);
        chk("lit_decerr_resp", rresp_o, 2'd3);
        @(posedge clk);
        #1;

        // ID mismatch
        set_beat(0, 64'hE000_0000_0000_0001, 6'h03, 2'd0, 8'h71);
        set_beat(1, 64'hE000_0000_0000_0002, 6'h09, 2'd0, 8'h72);
        send_burst(2, 1'b0, 1'b1);

        // Short burst
        set_beat(0, 64'hAAAA_BBBB_CCCC_DDDD, 6'h04, 2'd0, 8'h81);
        send_burst(1, 1'b0, 1'b1);
        @(negedge clk);
        chk("lit_short_line", line_o, 128'h0000_0000_0000_0000_AAAA_BBBB_CCCC_DDDD);
        chk("lit_short_err", err_o, 1);
        chk("lit_short_resp", rresp_o, 2'd2);
        @(posedge clk);
        #1;

        // Long burst then a normal one
        for (int k = 0; k < 4; k++) set_beat(k, 64'hF000_0000_0000_0000 + 64'(k), 6'h0A, 2'd0, 8'h90);
        send_burst(4, 1'b0, 1'b1);
        set_beat(0, 64'h0123_4567_89AB_CDEF, 6'h0B, 2'd0, 8'h91);
        set_beat(1, 64'hFEDC_BA98_7654_3210, 6'h0B, 2'd1, 8'h92);
        send_burst(2, 1'b0, 1'b1);

        // Bypass beat then a cached burst
        set_beat(0, 64'hDEAD_BEEF_0000_0001, 6'h0C, 2'd0, 8'hA1);
        send_burst(1, 1'b1, 1'b1);
        @(negedge clk);
        chk("lit_bypass_flag", bypass_o, 1);
        chk("lit_bypass_line", line_o, 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0001);
        chk("lit_bypass_err", err_o, 0);
        @(posedge clk);
        #1;
        set_beat(0, 64'h1357_9BDF_0000_0001, 6'h0D, 2'd0, 8'hB1);
        set_beat(1, 64'h1357_9BDF_0000_0002, 6'h0D, 2'd0, 8'hB2);
        send_burst(2, 1'b0, 1'b1);
        drain();

        // Backpressure: three bursts against a 2-entry buffer
        ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    set_beat(0, {32'h7000_0000 + 32'(i), 32'h0000_0001}, 6'(16 + i), 2'd0, 8'(i));
                    set_beat(1, {32'h7000_0000 + 32'(i), 32'h0000_0002}, 6'(16 + i), 2'd0, 8'(i));
                    send_burst(2, 1'b0, 1'b1);
                end
            end
            begin
                repeat (8) @(negedge clk);
                chk("bp_rready_low", rready_o, 0);
                chk("bp_valid", valid_o, 1);
                @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a burst
        set_beat(0, 64'h9999_0000_0000_0001, 6'h1F, 2'd0, 8'hEE);
        rvalid_i = 1'b1; rdata_i = b_data[0]; rid_i = b_id[0]; rresp_i = b_resp[0];
        ruser_i = b_user[0]; rlast_i = 1'b0; bypass_i = 1'b0;
        wait_accept();
        rvalid_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_rready", rready_o, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_beat(0, 64'h2468_0000_0000_0001, 6'h12, 2'd0, 8'hC1);
        set_beat(1, 64'h2468_0000_0000_0002, 6'h12, 2'd0, 8'hC2);
        send_burst(2, 1'b0, 1'b1);
        drain();

        // One beat per line instance
        send1(128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, 2'd0, 1'b1);
        @(negedge clk);
        chk("b1_a_valid", b1_valid, 1);
        chk("b1_a_line", b1_line, 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10);
        chk("b1_a_err", b1_err, 0);
        chk("b1_a_rid", b1_rid_o, 6'h2A);
        chk("b1_a_user", b1_user_o, 8'hC3);
        chk("b1_a_byp", b1_byp_o, 0);
        @(posedge clk);
        #1;
        send1(128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0, 2'd3, 1'b1);
        @(negedge clk);
        chk("b1_b_line", b1_line, 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0);
        chk("b1_b_resp", b1_resp_o, 2'd3);
        @(posedge clk);
        #1;
        send1(128'h5A5A_5A5A_0000_0000_0000_0000_0000_0001, 2'd1, 1'b0);
        @(negedge clk);
        chk("b1_long_valid", b1_valid, 1);
        chk("b1_long_err", b1_err, 1);
        chk("b1_long_resp", b1_resp_o, 2'd2);
        @(posedge clk);
        #1;
        send1(128'h5A5A_5A5A_0000_0000_0000_0000_0000_0002, 2'd0, 1'b1);
        @(negedge clk);
        chk("b1_drain_novalid", b1_valid, 0);
        @(posedge clk);
        #1;

        chk("output_count", n_out, n_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
